// File: rtl/ifetch_ctrl.sv
// Byte-serial instruction fetch: assembles big-endian words MSB-first into a FIFO_DEPTH queue for decode.
// Optional IFETCH_PREDECODE_EN: an assembled j word (opcode 6'h02) self-redirects fetch to its target.
module ifetch_ctrl #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                MEM_BYTES  = 64,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              fault
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FAULT} state_t;

  localparam int                PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int                CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_BYTES - 4);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]        k_q, k_d;
  logic [1:0]        ifw_q, ifw_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_last_q, rd_last_d;
  logic [ADDR_W-1:0] rd_wpc_q, rd_wpc_d;
  logic [23:0]       asm_q, asm_d;
  logic [31:0]       q_instr_q [FIFO_DEPTH];
  logic [31:0]       q_instr_d [FIFO_DEPTH];
  logic [ADDR_W-1:0] q_pc_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] q_pc_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic        push, pop, issue, start, ext_redir;
  logic [31:0] word;
  int          occ;
`ifdef IFETCH_PREDECODE_EN
  logic [ADDR_W-1:0] pc_plus4;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == FIFO_DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  assign out_valid = (count_q != '0);
  assign out_instr = out_valid ? q_instr_q[rd_ptr_q] : '0;
  assign out_pc    = out_valid ? q_pc_q[rd_ptr_q] : '0;
  assign fault     = (state_q == FAULT);
  assign mem_addr  = fetch_pc_q + ADDR_W'(k_q);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    k_d        = k_q;
    ifw_d      = ifw_q;
    rd_vld_d   = 1'b0;
    rd_last_d  = 1'b0;
    rd_wpc_d   = rd_wpc_q;
    asm_d      = asm_q;
    q_instr_d  = q_instr_q;
    q_pc_d     = q_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    mem_rd     = 1'b0;
    push       = 1'b0;
    issue      = 1'b0;
    start      = 1'b0;
    ext_redir  = redirect && (state_q != FAULT);
    word       = {asm_q, mem_rdata};
    occ        = int'(count_q) + int'(ifw_q);
    pop        = out_valid && out_ready;
`ifdef IFETCH_PREDECODE_EN
    pc_plus4   = rd_wpc_q + ADDR_W'(4);
`endif

    if (rd_vld_q) begin
      asm_d = {asm_q[15:0], mem_rdata};
      push  = rd_last_q;
    end

    case (state_q)
      IDLE: state_d = FETCH;
      FETCH, HOLD: begin
        if (k_q != 2'd0) begin
          issue = 1'b1;
        end else if (fetch_pc_q > LAST_PC) begin
          // Out-of-range fetch waits until older words have been delivered.
          state_d = (occ == 0) ? FAULT : HOLD;
        end else if (occ < FIFO_DEPTH) begin
          issue   = 1'b1;
          start   = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      default: ;
    endcase

    if (issue) begin
      mem_rd    = 1'b1;
      rd_vld_d  = 1'b1;
      rd_last_d = (k_q == 2'd3);
      rd_wpc_d  = fetch_pc_q;
      k_d       = k_q + 2'd1;
      if (k_q == 2'd3) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    end
    ifw_d = ifw_q + 2'(start) - 2'(push);

    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push) begin
      q_instr_d[wr_ptr_q] = word;
      q_pc_d[wr_ptr_q]    = rd_wpc_q;
      wr_ptr_d            = ptr_inc(wr_ptr_q);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

`ifdef IFETCH_PREDECODE_EN
    // The j word itself is queued; only the word started behind it is dropped.
    if (push && word[31:26] == 6'h02) begin
      fetch_pc_d = (pc_plus4 & ~ADDR_W'(32'h0FFF_FFFF)) | ADDR_W'({word[25:0], 2'b00});
      k_d        = 2'd0;
      ifw_d      = 2'd0;
      rd_vld_d   = 1'b0;
      rd_last_d  = 1'b0;
      state_d    = FETCH;
    end
`endif

    if (ext_redir) begin
      fetch_pc_d = redirect_pc;
      state_d    = (redirect_pc[1:0] != 2'b00) ? FAULT : FETCH;
    end

    if (ext_redir || state_d == FAULT) begin
      k_d       = 2'd0;
      ifw_d     = 2'd0;
      rd_vld_d  = 1'b0;
      rd_last_d = 1'b0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      k_q        <= 2'd0;
      ifw_q      <= 2'd0;
      rd_vld_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_wpc_q   <= '0;
      asm_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        q_instr_q[i] <= '0;
        q_pc_q[i]    <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      k_q        <= k_d;
      ifw_q      <= ifw_d;
      rd_vld_q   <= rd_vld_d;
      rd_last_q  <= rd_last_d;
      rd_wpc_q   <= rd_wpc_d;
      asm_q      <= asm_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      q_instr_q  <= q_instr_d;
      q_pc_q     <= q_pc_d;
    end
  end

endmodule
